// File: rtl/uart_phase_report_if.sv
// Bundles the measurement/acknowledge inputs and the serial/status outputs of
// uart_phase_report so the producer and the transmitter share one port.
interface uart_phase_report_if;
    logic [31:0] i_phase;
    logic        i_phase_valid;
    logic        i_ack_req;
    logic        o_uart_tx;
    logic        o_busy;
    logic        o_overrun;

    modport master (
        output i_phase, i_phase_valid, i_ack_req,
        input  o_uart_tx, o_busy, o_overrun
    );

    modport slave (
        input  i_phase, i_phase_valid, i_ack_req,
        output o_uart_tx, o_busy, o_overrun
    );
endinterface

// File: rtl/uart_phase_report.sv
// 8N1 UART transmitter that reports phase measurements as hex lines and
// acknowledges sync requests with "ok\r\n"; ACK wins at every message boundary.
module uart_phase_report #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HEX_DIGITS   = 8
) (
    input  logic                i_clk,
    input  logic                i_res_n,
    uart_phase_report_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  ACK_LAST   = 4'd3;
    localparam logic [3:0]  PHASE_LAST = 4'(HEX_DIGITS + 1);
    localparam logic [3:0]  CR_IDX     = 4'(HEX_DIGITS);
    localparam int          PAD        = 32 - 4 * HEX_DIGITS;

    state_t      state_q, state_d;
    logic [15:0] bitCnt_q, bitCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [3:0]  byteIdx_q, byteIdx_d;
    logic        msgPhase_q, msgPhase_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] pendVal_q, pendVal_d;
    logic        phasePend_q, phasePend_d;
    logic        ackPend_q, ackPend_d;
    logic        overrun_q, overrun_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    logic [7:0]  curByte;
    logic [3:0]  nibble;
    logic [3:0]  lastIdx;
    logic        bitTick;
    logic        boundary;
    logic        takeAck;
    logic        takePhase;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            bitIdx_q    <= '0;
            byteIdx_q   <= '0;
            msgPhase_q  <= 1'b0;
            shift_q     <= '0;
            pendVal_q   <= '0;
            phasePend_q <= 1'b0;
            ackPend_q   <= 1'b0;
            overrun_q   <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            bitIdx_q    <= bitIdx_d;
            byteIdx_q   <= byteIdx_d;
            msgPhase_q  <= msgPhase_d;
            shift_q     <= shift_d;
            pendVal_q   <= pendVal_d;
            phasePend_q <= phasePend_d;
            ackPend_q   <= ackPend_d;
            overrun_q   <= overrun_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    // The current digit always sits in the top nibble of the shift copy.
    always_comb begin
        curByte = 8'h0A;
        nibble  = shift_q[31:28];
        if (!msgPhase_q) begin
            case (byteIdx_q)
                4'd0:    curByte = 8'h6F;
                4'd1:    curByte = 8'h6B;
                4'd2:    curByte = 8'h0D;
                default: curByte = 8'h0A;
            endcase
        end else if (byteIdx_q < CR_IDX) begin
            curByte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
        end else if (byteIdx_q == CR_IDX) begin
            curByte = 8'h0D;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        bitIdx_d    = bitIdx_q;
        byteIdx_d   = byteIdx_q;
        msgPhase_d  = msgPhase_q;
        shift_d     = shift_q;
        pendVal_d   = pendVal_q;
        phasePend_d = phasePend_q;
        ackPend_d   = ackPend_q;
        overrun_d   = 1'b0;
        tx_d        = 1'b1;
        busy_d      = (state_q != IDLE) | ackPend_q | phasePend_q;

        bitTick   = (bitCnt_q == BIT_LAST);
        lastIdx   = msgPhase_q ? PHASE_LAST : ACK_LAST;
        boundary  = (state_q == IDLE) ||
                    ((state_q == STOP) && bitTick && (byteIdx_q == lastIdx));
        takeAck   = boundary && ackPend_q;
        takePhase = boundary && !ackPend_q && phasePend_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                tx_d     = 1'b0;
                bitCnt_d = bitTick ? 16'd0 : bitCnt_q + 16'd1;
                if (bitTick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d     = curByte[bitIdx_q];
                bitCnt_d = bitTick ? 16'd0 : bitCnt_q + 16'd1;
                if (bitTick) begin
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx_d     = 1'b1;
                bitCnt_d = bitTick ? 16'd0 : bitCnt_q + 16'd1;
                if (bitTick) begin
                    if (byteIdx_q != lastIdx) begin
                        byteIdx_d = byteIdx_q + 4'd1;
                        shift_d   = shift_q << 4;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Chaining at the final stop tick keeps queued messages gap-free.
        if (takeAck) begin
            ackPend_d  = 1'b0;
            msgPhase_d = 1'b0;
            byteIdx_d  = 4'd0;
            bitCnt_d   = 16'd0;
            state_d    = START;
        end else if (takePhase) begin
            phasePend_d = 1'b0;
            msgPhase_d  = 1'b1;
            shift_d     = pendVal_q << PAD;
            byteIdx_d   = 4'd0;
            bitCnt_d    = 16'd0;
            state_d     = START;
        end

        if (bus.i_ack_req) begin
            ackPend_d = 1'b1;
        end
        if (bus.i_phase_valid) begin
            pendVal_d   = bus.i_phase;
            phasePend_d = 1'b1;
            if (phasePend_q && !takePhase) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.o_uart_tx = tx_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: doc/uart_phase_report.md
Name: uart_phase_report

Overview:
- UART transmit-side companion to the command receiver; sends ASCII status and measurement lines back to the host over the same 8N1 serial link.
- Reports each PPS phase measurement as an 8-digit uppercase hex line terminated by CR LF.
- Sends an "ok" CR LF acknowledgement when the command path accepts a PPS sync request.
- Sits between the phase measurement logic and the board UART TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
HEX_DIGITS, 8, hex characters emitted per phase report; legal values 1..8

Ports:
i_clk  input  1  system clock
i_res_n  input  1  asynchronous active-low reset
i_phase  input  32  phase measurement value, sampled when i_phase_valid=1
i_phase_valid  input  1  single-cycle strobe: new measurement available
i_ack_req  input  1  single-cycle strobe: sync command accepted, send acknowledgement
o_uart_tx  output  1  serial TX line, idle high
o_busy  output  1  high while any message is being transmitted or is pending
o_overrun  output  1  single-cycle pulse: a pending phase value was overwritten before it was sent

Behaviour:
- Reset (asynchronous, active-low):
  - o_uart_tx=1, o_busy=0, o_overrun=0.
  - Pending flags are cleared and the FSM returns to IDLE.
  - Reset asserted mid-frame forces the line high immediately; the partial frame is abandoned and not resumed.
- Frame format:
  - 8N1, LSB first.
  - Start bit (0), 8 data bits, stop bit (1); each bit is exactly CLKS_PER_BIT cycles.
  - Consecutive bytes of a message are sent back to back with no idle gap between stop bit and next start bit.
- Messages:
  - ACK message: 0x6F 0x6B 0x0D 0x0A ("ok\r\n").
  - PHASE message: HEX_DIGITS characters, most significant nibble first, taken from the low 4*HEX_DIGITS bits of the captured value, then 0x0D 0x0A.
  - Nibble 0-9 encodes to 0x30-0x39; nibble A-F encodes to 0x41-0x46.
- Capture:
  - i_phase_valid=1 copies i_phase into a one-deep pending register and sets phase_pend.
  - If phase_pend is already set, the value is overwritten and o_overrun pulses for 1 cycle on the following cycle.
  - A value already being transmitted is never modified.
  - i_ack_req=1 sets ack_pend. A repeated request while ack_pend is set is merged and does not generate a pulse.
- FSM states:
  - IDLE: if ack_pend, select ACK (clear ack_pend) and go to START. Else if phase_pend, select PHASE (move pending to shift copy, clear phase_pend) and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive the 8 bits LSB first, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then, if bytes remain in the message, load the next byte and go to START; else go to IDLE.
  - The ACK always has priority at a message boundary. Messages are never interleaved mid-message.
- Latency:
  - With the FSM in IDLE, a strobe sampled at edge N is selected at edge N+1.
  - o_uart_tx, which is registered, goes low at edge N+2.
- Simultaneous events:
  - i_ack_req and i_phase_valid in the same cycle: both are captured; ACK is sent first, then PHASE.
  - A strobe arriving in the same cycle the FSM consumes a pending entry is captured as a new pending entry; it is not lost and does not count as overrun.
- o_busy = (state != IDLE) | ack_pend | phase_pend, registered. It drops the cycle after the final stop bit completes when nothing is pending.
- Counters:
  - Bit-time counter is 16-bit, counting 0..CLKS_PER_BIT-1 and wrapping.
  - Bit index is 0..7; byte index is 0..HEX_DIGITS+1.

Test Plan (CLKS_PER_BIT=4):
- Reset -> o_uart_tx=1, o_busy=0 throughout; assert reset mid-frame -> line high on the same cycle, no further edges after release.
- i_phase=0x12AB09FF pulse while idle -> UART monitor decodes "12AB09FF\r\n" (10 bytes, 400 cycles); o_uart_tx low at strobe edge +2; o_busy low right after the last stop bit.
- i_ack_req pulse while idle -> "ok\r\n" decoded, 160 cycles of activity.
- i_ack_req and i_phase_valid (0x00000000) in the same cycle -> "ok\r\n" then "00000000\r\n", back to back with no gap.
- During an active PHASE message, pulse i_phase_valid with 0x1, then 0x2 -> one o_overrun pulse; next message is "00000002\r\n"; the active message is unaltered.
- HEX_DIGITS=4, i_phase=0xDEADBEEF -> "BEEF\r\n".
